// File: rtl/rf_write_arbiter.sv
// Purpose: round-robin arbiter sharing the register-file write port between ALU (A) and load-return (M) writebacks, plus pending-write scoreboard.
// Latency: handshake at edge k drives RF_WRITE after edge k; commit at edge k+1 when BUSYWAIT is low; PENDING is registered (one cycle after PEND_SET).
// Backpressure: BUSYWAIT freezes the staged write and drops both READYs; otherwise the stage frees every cycle, so one write per cycle is sustained.
//
// Ports:
//   i_core_clk, i_rst       clock and synchronous active-high reset
//   i_busywait              data-memory stall; staged write is held while high
//   i_a_vld/i_a_addr/i_a_dat, o_a_rdy   ALU writeback request
//   i_m_vld/i_m_addr/i_m_dat, o_m_rdy   load-return writeback request
//   o_rf_write, o_rf_inaddress, o_rf_in register-file WRITE / INADDRESS / IN
//   i_pend_set, i_pend_addr, o_pending  issue-time scoreboard of outstanding writes
module rf_write_arbiter (
    input  logic       i_core_clk,
    input  logic       i_rst,
    input  logic       i_busywait,
    input  logic       i_a_vld,
    input  logic [2:0] i_a_addr,
    input  logic [7:0] i_a_dat,
    output logic       o_a_rdy,
    input  logic       i_m_vld,
    input  logic [2:0] i_m_addr,
    input  logic [7:0] i_m_dat,
    output logic       o_m_rdy,
    output logic       o_rf_write,
    output logic [2:0] o_rf_inaddress,
    output logic [7:0] o_rf_in,
    input  logic       i_pend_set,
    input  logic [2:0] i_pend_addr,
    output logic [7:0] o_pending
);

    // Round-robin pointer: 0 = A granted last, 1 = M granted last.
    logic       r_last_m;
    logic       r_rf_write;
    logic [2:0] r_rf_inaddress;
    logic [7:0] r_rf_in;
    logic [7:0] r_pending;

    logic       w_a_rdy;
    logic       w_m_rdy;
    logic       w_commit;
    logic [7:0] w_clr_mask;
    logic [7:0] w_set_mask;
    logic [7:0] w_pending_nxt;

    // With BUSYWAIT low the stage always frees at this edge (either empty or
    // committing), so the grant only needs to look at the stall and reset.
    always_comb begin
        w_a_rdy = 1'b0;
        w_m_rdy = 1'b0;
        if (!i_rst && !i_busywait) begin
            if (i_a_vld && i_m_vld) begin
                w_a_rdy = r_last_m;
                w_m_rdy = !r_last_m;
            end else begin
                w_a_rdy = i_a_vld;
                w_m_rdy = i_m_vld;
            end
        end
    end

    assign w_commit   = r_rf_write && !i_busywait;
    assign w_clr_mask = w_commit   ? (8'h01 << r_rf_inaddress) : 8'h00;
    assign w_set_mask = i_pend_set ? (8'h01 << i_pend_addr)    : 8'h00;
    // Set is applied after clear so a newly issued writer to the same register
    // keeps its bit when the older write commits on the same edge.
    assign w_pending_nxt = (r_pending & ~w_clr_mask) | w_set_mask;

    always_ff @(posedge i_core_clk) begin
        if (i_rst) begin
            r_last_m       <= 1'b0;
            r_rf_write     <= 1'b0;
            r_rf_inaddress <= 3'd0;
            r_rf_in        <= 8'd0;
            r_pending      <= 8'h00;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_a_rdy && i_a_vld) begin
                r_rf_write     <= 1'b1;
                r_rf_inaddress <= i_a_addr;
                r_rf_in        <= i_a_dat;
                r_last_m       <= 1'b0;
            end else if (w_m_rdy && i_m_vld) begin
                r_rf_write     <= 1'b1;
                r_rf_inaddress <= i_m_addr;
                r_rf_in        <= i_m_dat;
                r_last_m       <= 1'b1;
            end else if (!i_busywait) begin
                // Stage freed with nothing new to load; address/data keep
                // their last value since WRITE is low.
                r_rf_write <= 1'b0;
            end
        end
    end

    assign o_a_rdy        = w_a_rdy;
    assign o_m_rdy        = w_m_rdy;
    assign o_rf_write     = r_rf_write;
    assign o_rf_inaddress = r_rf_inaddress;
    assign o_rf_in        = r_rf_in;
    assign o_pending      = r_pending;

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

    logic       clk = 1'b0;
    logic       rst, busy;
    logic       a_vld, m_vld, pset;
    logic [2:0] a_addr, m_addr, paddr;
    logic [7:0] a_dat, m_dat;
    logic       a_rdy, m_rdy, rf_wr;
    logic [2:0] rf_addr;
    logic [7:0] rf_din, pend;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rf_write_arbiter dut (
        .i_core_clk     (clk),
        .i_rst          (rst),
        .i_busywait     (busy),
        .i_a_vld        (a_vld),
        .i_a_addr       (a_addr),
        .i_a_dat        (a_dat),
        .o_a_rdy        (a_rdy),
        .i_m_vld        (m_vld),
        .i_m_addr       (m_addr),
        .i_m_dat        (m_dat),
        .o_m_rdy        (m_rdy),
        .o_rf_write     (rf_wr),
        .o_rf_inaddress (rf_addr),
        .o_rf_in        (rf_din),
        .i_pend_set     (pset),
        .i_pend_addr    (paddr),
        .o_pending      (pend)
    );

    typedef struct {
        logic       rst, busy;
        logic       a_vld; logic [2:0] a_addr; logic [7:0] a_dat;
        logic       m_vld; logic [2:0] m_addr; logic [7:0] m_dat;
        logic       pset;  logic [2:0] paddr;
        logic       e_ardy, e_mrdy, e_wr;
        logic [2:0] e_addr; logic [7:0] e_din, e_pend;
    } vec_t;

    vec_t vec [19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; busy = v.busy;
        a_vld = v.a_vld; a_addr = v.a_addr; a_dat = v.a_dat;
        m_vld = v.m_vld; m_addr = v.m_addr; m_dat = v.m_dat;
        pset = v.pset; paddr = v.paddr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference: staged write, round-robin owner, scoreboard bits.
    logic       md_last_m;
    logic       md_st_v;
    logic [2:0] md_st_addr;
    logic [7:0] md_st_dat;
    logic       md_pend [8];
    logic       ea, em;

    function automatic logic [7:0] md_pend_vec();
        logic [7:0] v;
        for (int b = 0; b < 8; b++) v[b] = md_pend[b];
        return v;
    endfunction

    task automatic md_grant();
        ea = 1'b0; em = 1'b0;
        if (!rst && !busy) begin
            if (a_vld && m_vld) begin
                if (md_last_m) ea = 1'b1; else em = 1'b1;
            end else begin
                ea = a_vld; em = m_vld;
            end
        end
    endtask

    task automatic md_edge();
        if (rst) begin
            md_last_m = 1'b0; md_st_v = 1'b0; md_st_addr = 3'd0; md_st_dat = 8'd0;
            for (int b = 0; b < 8; b++) md_pend[b] = 1'b0;
        end else begin
            if (md_st_v && !busy) md_pend[md_st_addr] = 1'b0;
            if (pset) md_pend[paddr] = 1'b1;
            if (ea) begin
                md_st_v = 1'b1; md_st_addr = a_addr; md_st_dat = a_dat; md_last_m = 1'b0;
            end else if (em) begin
                md_st_v = 1'b1; md_st_addr = m_addr; md_st_dat = m_dat; md_last_m = 1'b1;
            end else if (!busy) begin
                md_st_v = 1'b0;
            end
        end
    endtask

    initial begin
        logic a_hold, m_hold;
        vec_t idle;
        idle = '{1'b0,1'b0, 1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 1'b0,3'd0, 1'b0,1'b0,1'b0,3'd0,8'h00,8'h00};
        drive(idle);

        //        rst  busy  a_vld a_addr a_dat   m_vld m_addr m_dat   pset paddr  ardy mrdy wr   addr  din    pend
        vec[0]  = '{1'b1,1'b0, 1'b1,3'd0,8'h00, 1'b0,3'd0,8'h00, 1'b0,3'd0, 1'b0,1'b0,1'b0,3'd0,8'h00,8'h00};
        vec[1]  = '{1'b0,1'b0, 1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 1'b1,3'd3, 1'b0,1'b0,1'b0,3'd0,8'h00,8'h08};
        vec[2]  = '{1'b0,1'b0, 1'b1,3'd3,8'hFB, 1'b0,3'd0,8'h00, 1'b0,3'd0, 1'b1,1'b0,1'b1,3'd3,8'hFB,8'h08};
        vec[3]  = '{1'b0,1'b0, 1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 1'b0,3'd0, 1'b0,1'b0,1'b0,3'd3,8'hFB,8'h00};
        vec[4]  = '{1'b1,1'b0, 1'b1,3'd1,8'd10, 1'b1,3'd2,8'd20, 1'b0,3'd0, 1'b0,1'b0,1'b0,3'd0,8'h00,8'h00};
        vec[5]  = '{1'b0,1'b0, 1'b1,3'd1,8'd10, 1'b1,3'd2,8'd20, 1'b0,3'd0, 1'b0,1'b1,1'b1,3'd2,8'd20,8'h00};
        vec[6]  = '{1'b0,1'b0, 1'b1,3'd1,8'd10, 1'b0,3'd0,8'h00, 1'b0,3'd0, 1'b1,1'b0,1'b1,3'd1,8'd10,8'h00};
        vec[7]  = '{1'b0,1'b0, 1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 1'b0,3'd0, 1'b0,1'b0,1'b0,3'd1,8'd10,8'h00};
        vec[8]  = '{1'b0,1'b0, 1'b1,3'd4,8'd7,  1'b0,3'd0,8'h00, 1'b1,3'd4, 1'b1,1'b0,1'b1,3'd4,8'd7, 8'h10};
        vec[9]  = '{1'b0,1'b1, 1'b0,3'd0,8'h00, 1'b1,3'd6,8'h37, 1'b0,3'd0, 1'b0,1'b0,1'b1,3'd4,8'd7, 8'h10};
        vec[10] = vec[9];
        vec[11] = vec[9];
        vec[12] = '{1'b0,1'b0, 1'b0,3'd0,8'h00, 1'b1,3'd6,8'h37, 1'b0,3'd0, 1'b0,1'b1,1'b1,3'd6,8'h37,8'h00};
        vec[13] = '{1'b0,1'b0, 1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 1'b1,3'd6, 1'b0,1'b0,1'b0,3'd6,8'h37,8'h40};
        vec[14] = '{1'b0,1'b0, 1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 1'b0,3'd0, 1'b0,1'b0,1'b0,3'd6,8'h37,8'h40};
        vec[15] = '{1'b0,1'b0, 1'b1,3'd5,8'h80, 1'b0,3'd0,8'h00, 1'b0,3'd0, 1'b1,1'b0,1'b1,3'd5,8'h80,8'h40};
        vec[16] = '{1'b0,1'b1, 1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 1'b0,3'd0, 1'b0,1'b0,1'b1,3'd5,8'h80,8'h40};
        vec[17] = '{1'b1,1'b1, 1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 1'b0,3'd0, 1'b0,1'b0,1'b0,3'd0,8'h00,8'h00};
        vec[18] = idle;

        tick();
        for (int i = 0; i < 19; i++) begin
            drive(vec[i]);
            #1;
            chk($sformatf("vec%0d_a_rdy", i), 32'(a_rdy), 32'(vec[i].e_ardy));
            chk($sformatf("vec%0d_m_rdy", i), 32'(m_rdy), 32'(vec[i].e_mrdy));
            tick();
            chk($sformatf("vec%0d_rf_write", i), 32'(rf_wr),   32'(vec[i].e_wr));
            chk($sformatf("vec%0d_rf_addr", i),  32'(rf_addr), 32'(vec[i].e_addr));
            chk($sformatf("vec%0d_rf_in", i),    32'(rf_din),  32'(vec[i].e_din));
            chk($sformatf("vec%0d_pending", i),  32'(pend),    32'(vec[i].e_pend));
        end

        // Fairness: both sources always valid, fresh data per accept.
        drive(idle);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_vld = 1'b1; a_addr = 3'd1; a_dat = 8'hA0;
        m_vld = 1'b1; m_addr = 3'd2; m_dat = 8'hC0;
        for (int i = 0; i < 8; i++) begin
            logic       exp_m;
            logic [7:0] exp_d;
            exp_m = (i % 2 == 0);
            exp_d = exp_m ? m_dat : a_dat;
            #1;
            chk($sformatf("rr%0d_a_rdy", i), 32'(a_rdy), 32'(!exp_m));
            chk($sformatf("rr%0d_m_rdy", i), 32'(m_rdy), 32'(exp_m));
            tick();
            chk($sformatf("rr%0d_rf_in", i),    32'(rf_din),  32'(exp_d));
            chk($sformatf("rr%0d_rf_addr", i),  32'(rf_addr), exp_m ? 32'd2 : 32'd1);
            chk($sformatf("rr%0d_rf_write", i), 32'(rf_wr),   32'd1);
            if (exp_m) m_dat = m_dat + 8'd1; else a_dat = a_dat + 8'd1;
        end

        // Randomized run against the reference model.
        drive(idle);
        rst = 1'b1;
        md_grant();
        tick();
        md_edge();
        a_hold = 1'b0; m_hold = 1'b0;
        for (int c = 0; c < 600; c++) begin
            rst  = ($urandom_range(0, 59) == 0);
            busy = ($urandom_range(0, 99) < 30);
            if (!a_hold) begin
                a_vld = 1'($urandom_range(0, 1)); a_addr = 3'($urandom_range(0, 7)); a_dat = 8'($urandom_range(0, 255));
            end
            if (!m_hold) begin
                m_vld = 1'($urandom_range(0, 1)); m_addr = 3'($urandom_range(0, 7)); m_dat = 8'($urandom_range(0, 255));
            end
            pset  = ($urandom_range(0, 2) == 0);
            paddr = 3'($urandom_range(0, 7));
            md_grant();
            #1;
            chk("rand_a_rdy", 32'(a_rdy), 32'(ea));
            chk("rand_m_rdy", 32'(m_rdy), 32'(em));
            tick();
            md_edge();
            chk("rand_rf_write", 32'(rf_wr), 32'(md_st_v));
            if (md_st_v) begin
                chk("rand_rf_addr", 32'(rf_addr), 32'(md_st_addr));
                chk("rand_rf_in",   32'(rf_din),  32'(md_st_dat));
            end
            chk("rand_pending", 32'(pend), 32'(md_pend_vec()));
            a_hold = a_vld && !ea;
            m_hold = m_vld && !em;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
